// File: rtl/piso_stream_serializer_if.sv
// Handshake bundle for the parallel-in/serial-out serializer.
// The slave view belongs to the serializer. The master view belongs to
// whatever drives the parallel side and consumes the serial side.
interface piso_stream_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             dout_sof;
  logic             dout_eof;

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, dout_sof, dout_eof
  );

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, dout_sof, dout_eof
  );
endinterface

// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out converter with valid/ready on both sides.
// The first bit of a word goes straight into dout_q when the word is loaded.
// The shift register keeps only the remaining bits, pre-shifted so that its
// output end always holds the next bit to send. When the last bit is consumed
// and a new word is offered in the same cycle, the new word is loaded with no
// gap between words.
module piso_stream_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  piso_stream_serializer_if.slave     bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  logic             busy_q,  busy_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             dout_q,  dout_d;
  logic             sof_q,   sof_d;
  logic             eof_q,   eof_d;

  logic last;
  logic din_ready;
  logic accept;
  logic beat;

  assign last      = busy_q && (cnt_q == CNT_LAST);
  assign din_ready = !busy_q || (bus.dout_ready && last);
  assign accept    = bus.din_valid && din_ready;
  // dout_valid is exactly the busy flag, so it stays a registered output.
  assign beat      = busy_q && bus.dout_ready;

  // Next-state: load on accept, shift on a mid-word beat, go idle after the last beat.
  always_comb begin
    busy_d  = busy_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    sof_d   = sof_q;
    eof_d   = eof_q;
    if (accept) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      sof_d  = 1'b1;
      eof_d  = 1'b0;
      if (LSB_FIRST) begin
        dout_d  = bus.din[0];
        shreg_d = bus.din >> 1;
      end else begin
        dout_d  = bus.din[WIDTH-1];
        shreg_d = bus.din << 1;
      end
    end else if (beat) begin
      if (last) begin
        busy_d = 1'b0;
        dout_d = 1'b0;
        sof_d  = 1'b0;
        eof_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sof_d = 1'b0;
        eof_d = (cnt_d == CNT_LAST);
        if (LSB_FIRST) begin
          dout_d  = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end else begin
          dout_d  = shreg_q[WIDTH-1];
          shreg_d = shreg_q << 1;
        end
      end
    end
  end

  // State register; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = busy_q;
  assign bus.dout_sof   = sof_q;
  assign bus.dout_eof   = eof_q;

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Directed bench for piso_stream_serializer.
// It uses three instances: 8-bit MSB-first, 8-bit LSB-first and 5-bit MSB-first.
module tb_piso_stream_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   assert_cnt = 0;
  int   fail_cnt   = 0;

  always #5 clk = ~clk;

  piso_stream_serializer_if #(.WIDTH(8)) a_if ();
  piso_stream_serializer_if #(.WIDTH(8)) b_if ();
  piso_stream_serializer_if #(.WIDTH(5)) c_if ();

  piso_stream_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  piso_stream_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
  piso_stream_serializer #(.WIDTH(5), .LSB_FIRST(1'b0)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [7:0] d, input logic v, input logic r);
    case (sel)
      0: begin a_if.din = d;      a_if.din_valid = v; a_if.dout_ready = r; end
      1: begin b_if.din = d;      b_if.din_valid = v; b_if.dout_ready = r; end
      default: begin c_if.din = d[4:0]; c_if.din_valid = v; c_if.dout_ready = r; end
    endcase
  endtask

  task automatic sample(input int sel, output logic d, output logic v, output logic s,
                        output logic e, output logic r);
    case (sel)
      0: begin d = a_if.dout; v = a_if.dout_valid; s = a_if.dout_sof; e = a_if.dout_eof; r = a_if.din_ready; end
      1: begin d = b_if.dout; v = b_if.dout_valid; s = b_if.dout_sof; e = b_if.dout_eof; r = b_if.din_ready; end
      default: begin d = c_if.dout; v = c_if.dout_valid; s = c_if.dout_sof; e = c_if.dout_eof; r = c_if.din_ready; end
    endcase
  endtask

  // Streams one word, or two words back-to-back, with dout_ready held high.
  // Beat i must carry exp_seq[total-1-i], so exp_seq is read left to right.
  task automatic run_words(input int sel, input int width, input logic [7:0] w0,
                           input logic [7:0] w1, input int nwords,
                           input logic [63:0] exp_seq, input string tag);
    logic d, v, s, e, r;
    int total;
    total = nwords * width;
    @(negedge clk);
    drive(sel, w0, 1'b1, 1'b1);
    #1;
    sample(sel, d, v, s, e, r);
    check_val({tag, " idle ready"}, 64'(r), 64'd1);
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      sample(sel, d, v, s, e, r);
      check_val($sformatf("%s beat%0d dout", tag, i), 64'(d), 64'(exp_seq[total-1-i]));
      check_val($sformatf("%s beat%0d valid", tag, i), 64'(v), 64'd1);
      check_val($sformatf("%s beat%0d sof", tag, i), 64'(s), 64'((i % width) == 0));
      check_val($sformatf("%s beat%0d eof", tag, i), 64'(e), 64'((i % width) == width - 1));
      if (i == 0)
        check_val({tag, " busy ready"}, 64'(r), 64'd0);
      if (i == width - 1)
        check_val({tag, " eof ready"}, 64'(r), 64'd1);
      if (i == 0 && nwords == 2)
        drive(sel, w1, 1'b1, 1'b1);
      else if (i == (nwords - 1) * width)
        drive(sel, 8'h00, 1'b0, 1'b1);
    end
    @(negedge clk);
    sample(sel, d, v, s, e, r);
    check_val({tag, " after valid"}, 64'(v), 64'd0);
    check_val({tag, " after dout"}, 64'(d), 64'd0);
    $display("word %s: %0d beats checked, failures so far %0d", tag, total, fail_cnt);
  endtask

  initial begin
    logic d, v, s, e, r;
    logic [7:0] bp_seq;
    int idx;
    int stall;
    drive(0, 8'h00, 1'b0, 1'b1);
    drive(1, 8'h00, 1'b0, 1'b1);
    drive(2, 8'h00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sample(k, d, v, s, e, r);
      check_val($sformatf("reset%0d dout", k), 64'(d), 64'd0);
      check_val($sformatf("reset%0d valid", k), 64'(v), 64'd0);
      check_val($sformatf("reset%0d sof", k), 64'(s), 64'd0);
      check_val($sformatf("reset%0d eof", k), 64'(e), 64'd0);
      check_val($sformatf("reset%0d ready", k), 64'(r), 64'd1);
    end
    rst = 1'b0;

    // Basic MSB-first word.
    run_words(0, 8, 8'hA5, 8'h00, 1, 64'b10100101, "msbA5");
    // LSB-first word.
    run_words(1, 8, 8'h1E, 8'h00, 1, 64'b01111000, "lsb1E");
    // Back-to-back words with no bubble.
    run_words(0, 8, 8'hFF, 8'h00, 2, 64'hFF00, "b2b");

    // Backpressure: stall three cycles while bit 3 of A5 is on dout.
    bp_seq = 8'b10100101;
    @(negedge clk);
    drive(0, 8'hA5, 1'b1, 1'b1);
    idx = 0;
    stall = 0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      @(negedge clk);
      if (cyc == 0) drive(0, 8'h00, 1'b0, 1'b1);
      sample(0, d, v, s, e, r);
      check_val($sformatf("bp cyc%0d dout", cyc), 64'(d), 64'(bp_seq[7-idx]));
      check_val($sformatf("bp cyc%0d valid", cyc), 64'(v), 64'd1);
      check_val($sformatf("bp cyc%0d sof", cyc), 64'(s), 64'(idx == 0));
      check_val($sformatf("bp cyc%0d eof", cyc), 64'(e), 64'(idx == 7));
      if (idx == 3 && stall < 3) begin
        drive(0, 8'h00, 1'b0, 1'b0);
        #1;
        sample(0, d, v, s, e, r);
        check_val($sformatf("bp stall%0d ready", stall), 64'(r), 64'd0);
        stall++;
      end else begin
        drive(0, 8'h00, 1'b0, 1'b1);
        idx++;
      end
    end
    @(negedge clk);
    sample(0, d, v, s, e, r);
    check_val("bp after valid", 64'(v), 64'd0);
    $display("word bp: 8 beats with 3 stall cycles checked, failures so far %0d", fail_cnt);

    // Asynchronous reset after four bits of F0.
    @(negedge clk);
    drive(0, 8'hF0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) drive(0, 8'h00, 1'b0, 1'b1);
      sample(0, d, v, s, e, r);
      check_val($sformatf("rstF0 beat%0d dout", i), 64'(d), 64'd1);
    end
    #2;
    rst = 1'b1;
    #1;
    sample(0, d, v, s, e, r);
    check_val("async rst dout", 64'(d), 64'd0);
    check_val("async rst valid", 64'(v), 64'd0);
    check_val("async rst sof", 64'(s), 64'd0);
    check_val("async rst eof", 64'(e), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("word rstF0: aborted after 4 beats, failures so far %0d", fail_cnt);
    run_words(0, 8, 8'h81, 8'h00, 1, 64'b10000001, "post81");

    // Non-power-of-two width, streamed twice back-to-back.
    run_words(2, 5, 8'h16, 8'h16, 2, 64'b1011010110, "w5");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
